adder_16b: RTL and testbench
============================

Name: adder_16b

Overview:
Registered 16-bit binary adder with carry-in and carry-out, used as the add datapath inside the ALU.
- Combinational core is a ripple-carry chain of 16 one-bit full adders.
- Result, carry and status flags are captured in output registers; a valid strobe travels alongside the data.
- Sits between ALU operand-select muxes and the ALU result mux.

Parameters:
WIDTH, 16, operand/sum width in bits; the block is specified and verified at 16 only.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands on a, b, c_in are valid this cycle
a  input  16  operand A, unsigned or two's complement
b  input  16  operand B
c_in  input  1  carry-in, added as LSB weight 1
out_valid  output  1  sum/c_out/ovf/zero hold a new result
sum  output  16  registered (a + b + c_in) mod 2^16
c_out  output  1  registered carry out of bit 15 (unsigned overflow)
ovf  output  1  registered signed overflow
zero  output  1  registered flag, 1 when sum == 0

Behaviour:
Reset:
- rst_n low asynchronously clears all outputs (sum = 0, c_out = 0, ovf = 0, zero = 0, out_valid = 0), regardless of clk.
- Deassertion is taken synchronously by design-level reset synchronisation; the block samples normally on the first rising edge with rst_n high.

Arithmetic:
- Full 17-bit result {c_out, sum} = a + b + c_in.
- ovf = (a[15] == b[15]) && (sum[15] != a[15]).
- zero = (sum == 16'h0000); zero is independent of c_out.

Timing and handshake:
- Default latency is 1 cycle. On a rising edge with in_valid = 1, the result for that edge's a/b/c_in is registered and out_valid = 1 the following cycle.
- On an edge with in_valid = 0: out_valid goes to 0, and sum/c_out/ovf/zero hold their previous values (no update).
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- Reset asserted mid-stream discards any in-flight result; out_valid is 0 until the first post-reset valid input propagates.

Boundaries:
- 0xFFFF + 0x0000 + 1 gives sum 0x0000, c_out 1, zero 1.
- 0xFFFF + 0xFFFF + 1 gives sum 0xFFFF, c_out 1.
- X/Z on the inputs while in_valid = 0 must not corrupt the held outputs.

Optional Feature:
ADDER_PIPE2_EN
- Defined: two-stage pipeline.
  - Stage 1 adds bits [7:0] and registers the low sum, the mid carry, and the upper bytes of a and b.
  - Stage 2 adds bits [15:8] using the registered carry.
  - Latency is 2 cycles and throughput stays 1 per cycle.
  - out_valid is delayed through both stages.
  - Reset clears both stages.
- Undefined: single-stage design as above, latency 1.
- Arithmetic results are identical in both builds.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- a = 465, b = 987, c_in = 1, in_valid = 1 -> after the latency: sum = 1453 (0x05AD), c_out = 0, ovf = 0, zero = 0, out_valid = 1 for one cycle.
- a = 356, b = 74, c_in = 0 issued on the next cycle (back-to-back) -> sum = 430 (0x01AE) on the cycle after 1453; out_valid stays high across both results.
- a = 0xFFFF, b = 0x0000, c_in = 1 -> sum = 0x0000, c_out = 1, zero = 1, ovf = 0.
- a = 0x7FFF, b = 0x0001, c_in = 0 -> sum = 0x8000, ovf = 1, c_out = 0. Then a = 0x8000, b = 0x8000 -> sum = 0x0000, c_out = 1, ovf = 1, zero = 1.
- in_valid = 0 for 3 cycles with random a/b -> out_valid = 0 and sum holds the last result. Repeat all cases with ADDER_PIPE2_EN defined and check latency = 2.

Source files
------------

// File: rtl/adder_16b.sv
// Registered ripple-carry adder with carry in/out, signed overflow and zero flags.
// Define ADDER_PIPE2_EN to split the carry chain into two stages (latency 2 instead of 1).
module adder_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int HALF = WIDTH / 2;

  // Ripple chain operands; the upper half comes from stage registers when pipelined.
  logic [WIDTH-1:0] fa_a;
  logic [WIDTH-1:0] fa_b;
  logic [WIDTH-1:0] fa_ci;
  logic [WIDTH-1:0] fa_s;
  logic [WIDTH:1]   fa_c;
  logic             hi_carry;

  // Result selected for the output registers.
  logic             load_en;
  logic [WIDTH-1:0] res_sum;
  logic             res_msb_a;
  logic             res_msb_b;

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             zero_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      if (gi == 0) begin : g_cin
        assign fa_ci[gi] = c_in;
      end else if (gi == HALF) begin : g_mid
        assign fa_ci[gi] = hi_carry;
      end else begin : g_rip
        assign fa_ci[gi] = fa_c[gi];
      end
      assign fa_s[gi]   = fa_a[gi] ^ fa_b[gi] ^ fa_ci[gi];
      assign fa_c[gi+1] = (fa_a[gi] & fa_b[gi]) | (fa_ci[gi] & (fa_a[gi] ^ fa_b[gi]));
    end
  endgenerate

`ifdef ADDER_PIPE2_EN
  logic              s1_valid_reg;
  logic [HALF-1:0]   sum_lo_reg;
  logic              carry_mid_reg;
  logic [WIDTH-HALF-1:0] a_hi_reg;
  logic [WIDTH-HALF-1:0] b_hi_reg;

  // Low half adds the live inputs; high half adds the operands captured last cycle.
  assign fa_a      = {a_hi_reg, a[HALF-1:0]};
  assign fa_b      = {b_hi_reg, b[HALF-1:0]};
  assign hi_carry  = carry_mid_reg;
  assign load_en   = s1_valid_reg;
  assign res_sum   = {fa_s[WIDTH-1:HALF], sum_lo_reg};
  assign res_msb_a = a_hi_reg[WIDTH-HALF-1];
  assign res_msb_b = b_hi_reg[WIDTH-HALF-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      sum_lo_reg    <= '0;
      carry_mid_reg <= 1'b0;
      a_hi_reg      <= '0;
      b_hi_reg      <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        sum_lo_reg    <= fa_s[HALF-1:0];
        carry_mid_reg <= fa_c[HALF];
        a_hi_reg      <= a[WIDTH-1:HALF];
        b_hi_reg      <= b[WIDTH-1:HALF];
      end
    end
  end
`else
  assign fa_a      = a;
  assign fa_b      = b;
  assign hi_carry  = fa_c[HALF];
  assign load_en   = in_valid;
  assign res_sum   = fa_s;
  assign res_msb_a = a[WIDTH-1];
  assign res_msb_b = b[WIDTH-1];
`endif

  // Flags and sum only load on a valid result so idle inputs never disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      c_out_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      out_valid_reg <= load_en;
      if (load_en) begin
        sum_reg   <= res_sum;
        c_out_reg <= fa_c[WIDTH];
        ovf_reg   <= (res_msb_a == res_msb_b) && (res_sum[WIDTH-1] != res_msb_a);
        zero_reg  <= (res_sum == '0);
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_adder_16b.sv
// Self-checking bench for adder_16b: directed corner cases, mid-stream reset and
// random traffic compared against an arithmetic reference model with latency queue.
module tb_adder_16b;

`ifdef ADDER_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        c_in = 1'b0;
  logic        out_valid;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;
  logic        zero;

  adder_16b #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
  } txn_t;

  txn_t        q[$];
  logic        exp_v    = 1'b0;
  logic [15:0] exp_sum  = '0;
  logic        exp_c    = 1'b0;
  logic        exp_ovf  = 1'b0;
  logic        exp_zero = 1'b0;
  int          n_vec = 0;
  int          n_mis = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the transaction sampled LAT-1 edges ago is what the outputs show now.
  task automatic model_edge();
    txn_t t;
    int   r;
    int   sr;
    t.v = in_valid; t.a = a; t.b = b; t.c = c_in;
    q.push_back(t);
    if (q.size() > LAT) q.delete(0);
    exp_v = 1'b0;
    if (q.size() == LAT && q[0].v) begin
      r  = int'(q[0].a) + int'(q[0].b) + int'(q[0].c);
      sr = int'($signed(q[0].a)) + int'($signed(q[0].b)) + int'(q[0].c);
      exp_v    = 1'b1;
      exp_sum  = r[15:0];
      exp_c    = r[16];
      exp_ovf  = (sr > 32767) || (sr < -32768);
      exp_zero = (r % 65536) == 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_v});
    check({tag, ".sum"},       sum,                exp_sum);
    check({tag, ".c_out"},     {15'd0, c_out},     {15'd0, exp_c});
    check({tag, ".ovf"},       {15'd0, ovf},       {15'd0, exp_ovf});
    check({tag, ".zero"},      {15'd0, zero},      {15'd0, exp_zero});
  endtask

  task automatic step(input string tag, input logic v, input logic [15:0] aa,
                      input logic [15:0] bb, input logic cc);
    @(negedge clk);
    in_valid = v; a = aa; b = bb; c_in = cc;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    $display("step %-8s v=%0d a=%h b=%h c=%0d -> ov=%0d sum=%h c=%0d ovf=%0d z=%0d",
             tag, v, aa, bb, cc, out_valid, sum, c_out, ovf, zero);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Asserts reset mid-cycle and checks outputs clear with no clock edge in between.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, ".out_valid"}, {15'd0, out_valid}, 16'd0);
    check({tag, ".sum"},       sum,                16'd0);
    check({tag, ".c_out"},     {15'd0, c_out},     16'd0);
    check({tag, ".ovf"},       {15'd0, ovf},       16'd0);
    check({tag, ".zero"},      {15'd0, zero},      16'd0);
    $display("reset %-7s sum=%h ov=%0d", tag, sum, out_valid);
    q.delete();
    exp_v = 1'b0; exp_sum = '0; exp_c = 1'b0; exp_ovf = 1'b0; exp_zero = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    apply_reset("rst0");

    step("b2b_a", 1'b1, 16'd465, 16'd987, 1'b1);
    step("b2b_b", 1'b1, 16'd356, 16'd74,  1'b0);
    idle("idle", 3);
    check("held_430", sum, 16'h01AE);

    step("wrap0", 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    idle("flush", LAT);
    check("wrap0.sum",  sum, 16'h0000);
    check("wrap0.cout", {15'd0, c_out}, 16'd1);
    check("wrap0.zero", {15'd0, zero},  16'd1);

    step("povf", 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    step("novf", 1'b1, 16'h8000, 16'h8000, 1'b0);
    step("allf", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    idle("flush", LAT + 1);
    check("allf.sum",  sum, 16'hFFFF);
    check("allf.cout", {15'd0, c_out}, 16'd1);

    step("pre_rst", 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    step("pre_rst", 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    apply_reset("rst_mid");
    idle("post_rst", 3);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
    idle("drain", LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
